hpdcache_cmo_issuer: RTL and testbench

HPDCACHE_CMO_ISSUER -- requirements
Module: hpdcache_cmo_issuer

---
 rtl/hpdcache_pkg.sv | 37 +++
 rtl/hpdcache_cmo_watchdog.sv | 23 ++
 rtl/hpdcache_cmo_issuer.sv | 100 ++++++++++
 tb/tb_hpdcache_cmo_issuer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hpdcache_pkg.sv
// hpdcache_pkg: shared HPDcache request types, CMO op encodings and the core-to-handler op decode
package hpdcache_pkg;
  localparam int unsigned HPDCACHE_PA_WIDTH = 40;
  localparam int unsigned HPDCACHE_WAYS = 4;
  localparam int unsigned HPDCACHE_REQ_TRANS_ID_WIDTH = 6;
  localparam int unsigned HPDCACHE_REQ_WORDS = 2;
  localparam int unsigned HPDCACHE_WORD_WIDTH = 64;
  typedef logic [HPDCACHE_PA_WIDTH-1:0] hpdcache_req_addr_t;
  typedef logic [HPDCACHE_REQ_TRANS_ID_WIDTH-1:0] hpdcache_req_tid_t;
  typedef logic [HPDCACHE_REQ_WORDS-1:0][HPDCACHE_WORD_WIDTH-1:0] hpdcache_req_data_t;
  typedef logic [HPDCACHE_WAYS-1:0] hpdcache_way_vector_t;
  typedef struct packed {
    logic is_inval_all;
    logic is_inval_by_set;
    logic is_inval_by_nline;
    logic is_fence;
  } hpdcache_cmoh_op_t;
  typedef enum logic [2:0] {
    CMO_FENCE = 3'd0,
    CMO_INVAL_BY_NLINE = 3'd1,
    CMO_INVAL_BY_SET = 3'd2,
    CMO_INVAL_ALL = 3'd3
  } hpdcache_cmo_core_op_e;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESP} hpdcache_cmo_issuer_state_e;
  function automatic logic hpdcache_cmo_legal(input logic [2:0] op);
    return op <= CMO_INVAL_ALL;
  endfunction
  function automatic hpdcache_cmoh_op_t hpdcache_cmo_decode(input logic [2:0] op);
    hpdcache_cmoh_op_t d;
    d = '0;
    d.is_fence = op == CMO_FENCE;
    d.is_inval_by_nline = op == CMO_INVAL_BY_NLINE;
    d.is_inval_by_set = op == CMO_INVAL_BY_SET;
    d.is_inval_all = op == CMO_INVAL_ALL;
    return d;
  endfunction
endpackage

// File: rtl/hpdcache_cmo_watchdog.sv
// hpdcache_cmo_watchdog: saturating wait-cycle counter that pulses once on reaching TIMEOUT_CYCLES-1
module hpdcache_cmo_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear,
  input  logic enable,
  output logic pulse,
  output logic expired
);
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt;
  // count enabled cycles, restart on clear, stop at the limit
  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable && cnt != LIMIT) cnt <= cnt + 1'b1;
  end
  assign pulse = enable && cnt == LIMIT - 1'b1;
  assign expired = cnt == LIMIT;
endmodule

// File: rtl/hpdcache_cmo_issuer.sv
// hpdcache_cmo_issuer: serialises core CMO requests to the CMO handler; watchdog under HPDCACHE_CMO_WATCHDOG_EN
module hpdcache_cmo_issuer
  import hpdcache_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 core_req_valid_i,
  output logic                 core_req_ready_o,
  input  logic [2:0]           core_req_op_i,
  input  hpdcache_req_addr_t   core_req_addr_i,
  input  hpdcache_way_vector_t core_req_way_i,
  input  hpdcache_req_tid_t    core_req_tid_i,
  output logic                 core_rsp_valid_o,
  input  logic                 core_rsp_ready_i,
  output hpdcache_req_tid_t    core_rsp_tid_o,
  output logic                 core_rsp_error_o,
  output logic                 cmoh_req_valid_o,
  input  logic                 cmoh_req_ready_i,
  output hpdcache_cmoh_op_t    cmoh_req_op_o,
  output hpdcache_req_addr_t   cmoh_req_addr_o,
  output hpdcache_req_data_t   cmoh_req_wdata_o,
  input  logic                 cmoh_req_wait_i,
  output logic                 busy_o,
  output logic                 timeout_o
);
  hpdcache_cmo_issuer_state_e state, state_nxt;
  logic [2:0] op;
  hpdcache_req_addr_t addr;
  hpdcache_way_vector_t way;
  hpdcache_req_tid_t tid;
  logic error, accept, legal, timeout_hit, unused;
  assign unused = cmoh_req_wait_i;
  assign legal = hpdcache_cmo_legal(core_req_op_i);
  assign accept = state == IDLE && core_req_valid_i;
`ifdef HPDCACHE_CMO_WATCHDOG_EN
  logic wd_pulse, wd_expired;
  hpdcache_cmo_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear   (state == ISSUE && cmoh_req_ready_i),
    .enable  (state == WAIT_DONE),
    .pulse   (wd_pulse),
    .expired (wd_expired)
  );
  assign timeout_o = wd_pulse;
  assign timeout_hit = wd_pulse | wd_expired;
`else
  assign timeout_o = 1'b0;
  assign timeout_hit = 1'b0;
`endif
  // state register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= IDLE;
    else state <= state_nxt;
  end
  // next state: illegal ops skip the handler and answer directly
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      state_nxt = core_req_valid_i ? (legal ? ISSUE : RESP) : IDLE;
      ISSUE:     state_nxt = cmoh_req_ready_i ? WAIT_DONE : ISSUE;
      WAIT_DONE: state_nxt = cmoh_req_ready_i ? RESP : WAIT_DONE;
      RESP:      state_nxt = core_rsp_ready_i ? IDLE : RESP;
      default:   state_nxt = IDLE;
    endcase
  end
  // capture the request on accept; error is sticky once the watchdog fires
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      op <= '0;
      addr <= '0;
      way <= '0;
      tid <= '0;
      error <= 1'b0;
    end else begin
      if (accept) begin
        op <= core_req_op_i;
        addr <= core_req_addr_i;
        way <= core_req_way_i;
        tid <= core_req_tid_i;
      end
      error <= accept ? !legal : error | timeout_hit;
    end
  end
  // handler write data carries only the way mask in the low bits of word 0
  always_comb begin
    cmoh_req_wdata_o = '0;
    cmoh_req_wdata_o[0][HPDCACHE_WAYS-1:0] = way;
  end
  assign core_req_ready_o = state == IDLE;
  assign cmoh_req_valid_o = state == ISSUE;
  assign cmoh_req_op_o = cmoh_req_valid_o ? hpdcache_cmo_decode(op) : '0;
  assign cmoh_req_addr_o = addr;
  assign core_rsp_valid_o = state == RESP;
  assign core_rsp_tid_o = tid;
  assign core_rsp_error_o = error;
  assign busy_o = state != IDLE;
endmodule

// File: tb/tb_hpdcache_cmo_issuer.sv
// tb_hpdcache_cmo_issuer: randomized self-checking bench for the CMO issuer against a latency/response model
module tb_hpdcache_cmo_issuer;
  import hpdcache_pkg::*;
  localparam int unsigned TO = 8;
`ifdef HPDCACHE_CMO_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic core_req_valid_i = 1'b0, core_req_ready_o;
  logic [2:0] core_req_op_i = '0;
  hpdcache_req_addr_t core_req_addr_i = '0;
  hpdcache_way_vector_t core_req_way_i = '0;
  hpdcache_req_tid_t core_req_tid_i = '0;
  logic core_rsp_valid_o, core_rsp_ready_i = 1'b0, core_rsp_error_o;
  hpdcache_req_tid_t core_rsp_tid_o;
  logic cmoh_req_valid_o, cmoh_req_ready_i = 1'b0, cmoh_req_wait_i, busy_o, timeout_o;
  hpdcache_cmoh_op_t cmoh_req_op_o;
  hpdcache_req_addr_t cmoh_req_addr_o;
  hpdcache_req_data_t cmoh_req_wdata_o;
  int nvec = 0, nerr = 0;
  int o_hs, o_hs_cyc, o_rsp_cyc, o_pulses;
  hpdcache_cmoh_op_t o_op;
  hpdcache_req_addr_t o_addr;
  hpdcache_req_data_t o_wdata;
  hpdcache_req_tid_t o_tid;
  logic o_err;
  bit o_start_rdy, o_hold_ok, o_onehot_ok, o_idle_ok, o_excl_ok;

  always #5 clk = ~clk;
  assign cmoh_req_wait_i = !cmoh_req_ready_i;

  hpdcache_cmo_issuer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .core_req_valid_i(core_req_valid_i), .core_req_ready_o(core_req_ready_o),
    .core_req_op_i(core_req_op_i), .core_req_addr_i(core_req_addr_i),
    .core_req_way_i(core_req_way_i), .core_req_tid_i(core_req_tid_i),
    .core_rsp_valid_o(core_rsp_valid_o), .core_rsp_ready_i(core_rsp_ready_i),
    .core_rsp_tid_o(core_rsp_tid_o), .core_rsp_error_o(core_rsp_error_o),
    .cmoh_req_valid_o(cmoh_req_valid_o), .cmoh_req_ready_i(cmoh_req_ready_i),
    .cmoh_req_op_o(cmoh_req_op_o), .cmoh_req_addr_o(cmoh_req_addr_o),
    .cmoh_req_wdata_o(cmoh_req_wdata_o), .cmoh_req_wait_i(cmoh_req_wait_i),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  function automatic hpdcache_cmoh_op_t model_op(input logic [2:0] op);
    hpdcache_cmoh_op_t m;
    m = '0;
    case (op)
      3'd0: m.is_fence = 1'b1;
      3'd1: m.is_inval_by_nline = 1'b1;
      3'd2: m.is_inval_by_set = 1'b1;
      3'd3: m.is_inval_all = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

  function automatic bit model_timeout(input logic [2:0] op, input int dstall);
    return WD && op < 3'd4 && dstall >= int'(TO) - 1;
  endfunction

  function automatic int model_rsp_cyc(input logic [2:0] op, input int istall, input int dstall);
    return op < 3'd4 ? 3 + istall + dstall : 1;
  endfunction

  function automatic hpdcache_req_addr_t rand_addr();
    return hpdcache_req_addr_t'({$urandom(), $urandom()});
  endfunction

  // drives one request, plays the handler and the core response side, records what was seen
  task automatic run_txn(input logic [2:0] op, input hpdcache_req_addr_t addr, input hpdcache_way_vector_t way,
                         input hpdcache_req_tid_t tid, input int istall, input int dstall, input int rstall);
    int ic, dc, rc;
    bit hs_done, rsp_done, seen_v;
    o_hs = 0; o_hs_cyc = -1; o_rsp_cyc = -1; o_pulses = 0;
    o_hold_ok = 1; o_onehot_ok = 1; o_idle_ok = 0; o_excl_ok = 1;
    o_op = '0; o_addr = '0; o_wdata = '0; o_tid = '0; o_err = 1'bx;
    ic = 0; dc = 0; rc = 0; hs_done = 0; rsp_done = 0; seen_v = 0;
    @(negedge clk);
    o_start_rdy = core_req_ready_o;
    core_req_valid_i = 1'b1; core_req_op_i = op; core_req_addr_i = addr;
    core_req_way_i = way; core_req_tid_i = tid;
    cmoh_req_ready_i = istall == 0; core_rsp_ready_i = 1'b0;
    for (int c = 1; c <= 200 && !rsp_done; c++) begin
      @(negedge clk);
      if (c == 1) begin
        core_req_valid_i = 1'b0; core_req_op_i = 3'($urandom());
        core_req_addr_i = rand_addr(); core_req_way_i = 4'($urandom()); core_req_tid_i = 6'($urandom());
      end
      if (timeout_o) o_pulses++;
      if (cmoh_req_valid_o) begin
        if (!$onehot(cmoh_req_op_o)) o_onehot_ok = 0;
        if (!seen_v) begin
          seen_v = 1; o_op = cmoh_req_op_o; o_addr = cmoh_req_addr_o; o_wdata = cmoh_req_wdata_o;
        end else if (cmoh_req_op_o !== o_op || cmoh_req_addr_o !== o_addr || cmoh_req_wdata_o !== o_wdata) o_hold_ok = 0;
      end else if (cmoh_req_op_o !== '0) o_onehot_ok = 0;
      cmoh_req_ready_i = hs_done ? dc >= dstall : ic >= istall;
      if (cmoh_req_valid_o) begin
        if (cmoh_req_ready_i) begin o_hs++; hs_done = 1; o_hs_cyc = c; end
        else ic++;
      end else if (hs_done) dc++;
      if (core_rsp_valid_o) begin
        if (core_req_ready_o) o_excl_ok = 0;
        if (o_rsp_cyc < 0) begin o_rsp_cyc = c; o_tid = core_rsp_tid_o; o_err = core_rsp_error_o; end
        else if (core_rsp_tid_o !== o_tid || core_rsp_error_o !== o_err) o_hold_ok = 0;
        core_rsp_ready_i = rc >= rstall;
        if (core_rsp_ready_i) rsp_done = 1;
        else rc++;
      end else core_rsp_ready_i = 1'b0;
    end
    @(negedge clk);
    o_idle_ok = core_req_ready_o && !busy_o && !core_rsp_valid_o && !cmoh_req_valid_o;
    core_rsp_ready_i = 1'b0;
  endtask

  // reset holds the issuer idle even with a request pending
  task automatic test_reset();
    rst_ni = 1'b0; core_req_valid_i = 1'b1; core_req_op_i = 3'd1;
    core_req_addr_i = rand_addr(); cmoh_req_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    nvec++; if (core_req_ready_o !== 1'b1 || busy_o !== 1'b0) begin nerr++; $display("FAIL reset_idle: ready=%b busy=%b want 1/0", core_req_ready_o, busy_o); end
    nvec++; if ({cmoh_req_valid_o, core_rsp_valid_o, timeout_o} !== 3'b000) begin nerr++; $display("FAIL reset_valids: got %b want 000", {cmoh_req_valid_o, core_rsp_valid_o, timeout_o}); end
    nvec++; if (cmoh_req_op_o !== '0 || cmoh_req_addr_o !== '0 || cmoh_req_wdata_o !== '0) begin nerr++; $display("FAIL reset_regs: op=%h addr=%h want 0", cmoh_req_op_o, cmoh_req_addr_o); end
    nvec++; if (core_rsp_tid_o !== '0 || core_rsp_error_o !== 1'b0) begin nerr++; $display("FAIL reset_rsp: tid=%h err=%b want 0", core_rsp_tid_o, core_rsp_error_o); end
    core_req_valid_i = 1'b0;
    rst_ni = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fence();
    hpdcache_req_addr_t a = rand_addr();
    run_txn(3'd0, a, 4'hf, 6'h2a, 0, 0, 0);
    nvec++; if (o_start_rdy !== 1'b1) begin nerr++; $display("FAIL fence_ready: got %b want 1", o_start_rdy); end
    nvec++; if (o_hs !== 1) begin nerr++; $display("FAIL fence_handshakes: got %0d want 1", o_hs); end
    nvec++; if (o_op !== model_op(3'd0) || o_addr !== a) begin nerr++; $display("FAIL fence_req: op=%b addr=%h want %b %h", o_op, o_addr, model_op(3'd0), a); end
    nvec++; if (o_rsp_cyc !== 3) begin nerr++; $display("FAIL fence_latency: got %0d want 3", o_rsp_cyc); end
    nvec++; if (o_tid !== 6'h2a || o_err !== 1'b0) begin nerr++; $display("FAIL fence_rsp: tid=%h err=%b want 2a 0", o_tid, o_err); end
  endtask

  task automatic test_inval_by_set();
    hpdcache_req_data_t ew = '0;
    ew[0][3:0] = 4'b0101;
    run_txn(3'd2, rand_addr(), 4'b0101, 6'h11, 0, 5, 0);
    nvec++; if (o_wdata !== ew) begin nerr++; $display("FAIL set_wdata: got %h want %h", o_wdata, ew); end
    nvec++; if (!o_op.is_inval_by_set || o_hs !== 1) begin nerr++; $display("FAIL set_op: op=%b hs=%0d want set-bit 1", o_op, o_hs); end
    nvec++; if (o_rsp_cyc !== model_rsp_cyc(3'd2, 0, 5)) begin nerr++; $display("FAIL set_latency: got %0d want %0d", o_rsp_cyc, model_rsp_cyc(3'd2, 0, 5)); end
    nvec++; if (o_err !== 1'b0 || o_tid !== 6'h11) begin nerr++; $display("FAIL set_rsp: err=%b tid=%h want 0 11", o_err, o_tid); end
  endtask

  task automatic test_illegal();
    for (int op = 4; op < 8; op++) begin
      run_txn(3'(op), rand_addr(), 4'($urandom()), 6'(op + 8), 0, 0, 0);
      nvec++; if (o_hs !== 0 || o_onehot_ok !== 1'b1) begin nerr++; $display("FAIL illegal_noreq op%0d: hs=%0d want 0", op, o_hs); end
      nvec++; if (o_rsp_cyc !== 1) begin nerr++; $display("FAIL illegal_latency op%0d: got %0d want 1", op, o_rsp_cyc); end
      nvec++; if (o_err !== 1'b1 || o_tid !== 6'(op + 8)) begin nerr++; $display("FAIL illegal_rsp op%0d: err=%b tid=%h want 1 %h", op, o_err, o_tid, 6'(op + 8)); end
    end
  endtask

  task automatic test_issue_stall();
    hpdcache_req_addr_t a = rand_addr();
    run_txn(3'd1, a, 4'h0, 6'h3, 3, 0, 2);
    nvec++; if (o_hold_ok !== 1'b1 || o_addr !== a) begin nerr++; $display("FAIL stall_hold: hold=%b addr=%h want 1 %h", o_hold_ok, o_addr, a); end
    nvec++; if (o_hs !== 1 || o_hs_cyc !== 4) begin nerr++; $display("FAIL stall_handshake: n=%0d cyc=%0d want 1 4", o_hs, o_hs_cyc); end
    nvec++; if (o_rsp_cyc !== 6 || o_excl_ok !== 1'b1) begin nerr++; $display("FAIL stall_rsp: cyc=%0d excl=%b want 6 1", o_rsp_cyc, o_excl_ok); end
  endtask

  task automatic test_watchdog();
    run_txn(3'd3, rand_addr(), 4'h0, 6'h21, 0, 20, 0);
    nvec++; if (o_pulses !== int'(WD)) begin nerr++; $display("FAIL wd_pulses: got %0d want %0d", o_pulses, int'(WD)); end
    nvec++; if (o_err !== WD) begin nerr++; $display("FAIL wd_error: got %b want %b", o_err, WD); end
    nvec++; if (o_rsp_cyc !== 23) begin nerr++; $display("FAIL wd_latency: got %0d want 23", o_rsp_cyc); end
  endtask

  task automatic test_reset_mid();
    bit bad = 0;
    @(negedge clk);
    core_req_valid_i = 1'b1; core_req_op_i = 3'd3; core_req_addr_i = rand_addr();
    core_req_way_i = 4'hf; core_req_tid_i = 6'h3f; cmoh_req_ready_i = 1'b1; core_rsp_ready_i = 1'b1;
    @(negedge clk);
    core_req_valid_i = 1'b0;
    nvec++; if (cmoh_req_valid_o !== 1'b1) begin nerr++; $display("FAIL rstmid_issue: valid=%b want 1", cmoh_req_valid_o); end
    @(negedge clk);
    cmoh_req_ready_i = 1'b0;
    @(negedge clk);
    nvec++; if (busy_o !== 1'b1 || cmoh_req_valid_o !== 1'b0 || core_rsp_valid_o !== 1'b0) begin nerr++; $display("FAIL rstmid_wait: busy=%b valid=%b want 1 0", busy_o, cmoh_req_valid_o); end
    rst_ni = 1'b0;
    @(negedge clk);
    nvec++; if ({busy_o, cmoh_req_valid_o, core_rsp_valid_o, timeout_o, core_rsp_error_o} !== 5'b0 || core_req_ready_o !== 1'b1) begin
      nerr++; $display("FAIL rstmid_outputs: busy/v/rv/to/err=%b ready=%b want 00000 1", {busy_o, cmoh_req_valid_o, core_rsp_valid_o, timeout_o, core_rsp_error_o}, core_req_ready_o);
    end
    nvec++; if (core_rsp_tid_o !== '0 || cmoh_req_addr_o !== '0) begin nerr++; $display("FAIL rstmid_regs: tid=%h addr=%h want 0", core_rsp_tid_o, cmoh_req_addr_o); end
    rst_ni = 1'b1; cmoh_req_ready_i = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (core_rsp_valid_o || cmoh_req_valid_o || busy_o) bad = 1;
    end
    nvec++; if (bad) begin nerr++; $display("FAIL rstmid_abandon: activity after reset want none"); end
    core_rsp_ready_i = 1'b0;
  endtask

  // consecutive requests with random stalls, every observation checked against the model
  task automatic test_back_to_back();
    for (int n = 0; n < 40; n++) begin
      logic [2:0] op = 3'($urandom_range(0, 7));
      hpdcache_req_addr_t a = rand_addr();
      hpdcache_way_vector_t w = 4'($urandom());
      hpdcache_req_tid_t t = 6'($urandom());
      int is = $urandom_range(0, 4), ds = $urandom_range(0, 12), rs = $urandom_range(0, 3);
      bit lg = op < 3'd4;
      hpdcache_req_data_t ew = '0;
      ew[0][3:0] = w;
      run_txn(op, a, w, t, is, ds, rs);
      nvec++; if (o_hs !== int'(lg)) begin nerr++; $display("FAIL b2b_hs #%0d: got %0d want %0d", n, o_hs, int'(lg)); end
      nvec++; if (lg && (o_op !== model_op(op) || o_addr !== a)) begin nerr++; $display("FAIL b2b_req #%0d: op=%b addr=%h want %b %h", n, o_op, o_addr, model_op(op), a); end
      nvec++; if (op == 3'd2 && o_wdata !== ew) begin nerr++; $display("FAIL b2b_wdata #%0d: got %h want %h", n, o_wdata, ew); end
      nvec++; if (lg && o_hs_cyc !== 1 + is) begin nerr++; $display("FAIL b2b_hs_cyc #%0d: got %0d want %0d", n, o_hs_cyc, 1 + is); end
      nvec++; if (o_rsp_cyc !== model_rsp_cyc(op, is, ds)) begin nerr++; $display("FAIL b2b_latency #%0d: got %0d want %0d", n, o_rsp_cyc, model_rsp_cyc(op, is, ds)); end
      nvec++; if (o_tid !== t || o_err !== (!lg || model_timeout(op, ds))) begin nerr++; $display("FAIL b2b_rsp #%0d: tid=%h err=%b want %h %b", n, o_tid, o_err, t, !lg || model_timeout(op, ds)); end
      nvec++; if (o_pulses !== int'(model_timeout(op, ds))) begin nerr++; $display("FAIL b2b_timeout #%0d: got %0d want %0d", n, o_pulses, int'(model_timeout(op, ds))); end
      nvec++; if (!(o_hold_ok && o_onehot_ok && o_excl_ok && o_idle_ok && o_start_rdy)) begin
        nerr++; $display("FAIL b2b_protocol #%0d: hold=%b onehot=%b excl=%b idle=%b start=%b want all 1", n, o_hold_ok, o_onehot_ok, o_excl_ok, o_idle_ok, o_start_rdy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fence();
    test_inval_by_set();
    test_illegal();
    test_issue_stall();
    test_watchdog();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
